// File: rtl/alu_driver_pkg.sv
// Shared types and constants for the ALU driver: control encoding, FSM states,
// RV32I funct3 codes and a small decode helper.
// Ports: none (package).
package alu_driver_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned STAT_W     = 32;

  // Operation select presented to the external alu
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_control_t;

  // Request/execute/response sequencing of the driver
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } alu_driver_state_t;

  // RV32I OP / OP-IMM funct3 codes
  localparam logic [FUNCT3_W-1:0] FUNCT3_ADD  = 3'b000;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SLL  = 3'b001;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SLT  = 3'b010;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SLTU = 3'b011;
  localparam logic [FUNCT3_W-1:0] FUNCT3_XOR  = 3'b100;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SR   = 3'b101;
  localparam logic [FUNCT3_W-1:0] FUNCT3_OR   = 3'b110;
  localparam logic [FUNCT3_W-1:0] FUNCT3_AND  = 3'b111;

  // Only ADD/SUB and SRL/SRA give funct7[5] a meaning; elsewhere it is illegal
  function automatic logic funct7_5_allowed(input logic [FUNCT3_W-1:0] funct3);
    return (funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SR);
  endfunction

endpackage

// File: rtl/alu_driver_decoder.sv
// alu_decoder: combinational translation of funct3/funct7[5]/is_imm into an
// alu control code, a shift indicator and an illegal-encoding flag.
// Ports:
//   funct3   in  3            instr[14:12]
//   funct7_5 in  1            instr[30]
//   is_imm   in  1            1 = OP-IMM, 0 = OP
//   control  out alu_control_t decoded operation (ALU_ADD when illegal)
//   is_shift out 1            legal SLL/SRL/SRA, operand b needs masking
//   illegal  out 1            encoding not part of RV32I OP/OP-IMM
module alu_decoder
  import alu_driver_pkg::*;
(
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7_5,
  input  logic                is_imm,
  output alu_control_t        control,
  output logic                is_shift,
  output logic                illegal
);

  // Decode table; illegal encodings fall back to a harmless ADD
  always_comb begin
    control  = ALU_ADD;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      // ADDI has no SUB form, so funct7[5] is immediate data there
      FUNCT3_ADD:  control = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
      FUNCT3_SLL: begin
        control  = ALU_SLL;
        is_shift = 1'b1;
      end
      FUNCT3_SLT:  control = ALU_SLT;
      FUNCT3_SLTU: control = ALU_SLTU;
      FUNCT3_XOR:  control = ALU_XOR;
      FUNCT3_SR: begin
        control  = funct7_5 ? ALU_SRA : ALU_SRL;
        is_shift = 1'b1;
      end
      FUNCT3_OR:   control = ALU_OR;
      FUNCT3_AND:  control = ALU_AND;
      default:     control = ALU_ADD;
    endcase
    if (funct7_5 && !funct7_5_allowed(funct3)) begin
      control  = ALU_ADD;
      is_shift = 1'b0;
      illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_driver.sv
// alu_driver: initiator side of the ALU interface. Accepts one RV32I OP/OP-IMM
// request at a time, drives latched operands/control into an external alu,
// captures its result and flags, and returns them on a valid/ready channel.
// Optional statistics counters are built when ALU_DRIVER_STATS_EN is defined;
// otherwise stat_ops/stat_ovf are tied to zero.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_funct3/funct7_5/is_imm        instruction fields
//   req_a, req_b                      rs1 value, rs2 value or sign-extended imm
//   alu_a, alu_b, alu_control         registered drive into the alu
//   alu_result/overflow/zero/equal    alu outputs
//   rsp_valid/rsp_ready               response handshake
//   rsp_result/overflow/zero/equal    captured alu outputs
//   rsp_illegal                       request encoding was illegal
//   stat_ops, stat_ovf                completed responses / responses with overflow
module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [FUNCT3_W-1:0] req_funct3,
  input  logic                req_funct7_5,
  input  logic                req_is_imm,
  input  logic [N-1:0]        req_a,
  input  logic [N-1:0]        req_b,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output alu_control_t        alu_control,
  input  logic [N-1:0]        alu_result,
  input  logic                alu_overflow,
  input  logic                alu_zero,
  input  logic                alu_equal,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_result,
  output logic                rsp_overflow,
  output logic                rsp_zero,
  output logic                rsp_equal,
  output logic                rsp_illegal,
  output logic [STAT_W-1:0]   stat_ops,
  output logic [STAT_W-1:0]   stat_ovf
);

  localparam int unsigned SHAMT_W = $clog2(N);

  alu_driver_state_t state_q, state_d;
  alu_control_t      dec_control;
  logic              dec_is_shift;
  logic              dec_illegal;
  logic              illegal_q;
  logic              accept_c;
  logic              rsp_hs_c;

  alu_decoder u_decoder (
    .funct3   (req_funct3),
    .funct7_5 (req_funct7_5),
    .is_imm   (req_is_imm),
    .control  (dec_control),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  assign accept_c = (state_q == S_IDLE) && req_valid;
  assign rsp_hs_c = (state_q == S_RESP) && rsp_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; handshake outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
    end
  end

  // Operand/control latch; held between requests so the alu never sees a glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_ADD;
      illegal_q   <= 1'b0;
    end else if (accept_c) begin
      alu_a       <= req_a;
      // Shifts keep only the shamt field so imm funct7 bits cannot zero the result
      alu_b       <= dec_is_shift ? N'(req_b[SHAMT_W-1:0]) : req_b;
      alu_control <= dec_control;
      illegal_q   <= dec_illegal;
    end
  end

  // Response capture at the end of the execute cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_equal    <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_result   <= illegal_q ? '0 : alu_result;
      rsp_overflow <= alu_overflow && !illegal_q;
      rsp_zero     <= alu_zero     && !illegal_q;
      rsp_equal    <= alu_equal    && !illegal_q;
      rsp_illegal  <= illegal_q;
    end
  end

`ifdef ALU_DRIVER_STATS_EN
  logic [STAT_W-1:0] stat_ops_q;
  logic [STAT_W-1:0] stat_ovf_q;

  // Completed-response counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (rsp_hs_c) begin
      stat_ops_q <= stat_ops_q + STAT_W'(1);
      if (rsp_overflow) stat_ovf_q <= stat_ovf_q + STAT_W'(1);
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs_c;
  assign stat_ops  = '0;
  assign stat_ovf  = '0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: behavioural alu model on the alu side,
// a directed vector table, randomized requests against a reference model, and
// hand-written backpressure and mid-operation reset sequences.
module tb_alu_driver;
  import alu_driver_pkg::*;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_funct3;
  logic         req_funct7_5;
  logic         req_is_imm;
  logic [31:0]  req_a;
  logic [31:0]  req_b;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  alu_control_t alu_control;
  logic [31:0]  alu_result;
  logic         alu_overflow;
  logic         alu_zero;
  logic         alu_equal;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_result;
  logic         rsp_overflow;
  logic         rsp_zero;
  logic         rsp_equal;
  logic         rsp_illegal;
  logic [31:0]  stat_ops;
  logic [31:0]  stat_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_ops   = 0;
  int hs_ovf   = 0;

  typedef struct {
    logic [2:0]   f3;
    logic         f7;
    logic         imm;
    logic [31:0]  a;
    logic [31:0]  b;
    alu_control_t ctrl;
    logic [31:0]  alu_b;
    logic [31:0]  result;
    logic         ovf;
    logic         zero;
    logic         eq;
    logic         ill;
  } vec_t;

  vec_t vecs[$];

  alu_driver #(.N(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_funct7_5 (req_funct7_5),
    .req_is_imm   (req_is_imm),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_equal    (alu_equal),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_equal    (rsp_equal),
    .rsp_illegal  (rsp_illegal),
    .stat_ops     (stat_ops),
    .stat_ovf     (stat_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural external alu; shift amounts use the full b operand
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      ALU_SLL:  alu_result = alu_a << alu_b;
      ALU_SRL:  alu_result = alu_a >> alu_b;
      ALU_SRA:  alu_result = 32'($signed(alu_a) >>> alu_b);
      ALU_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = '0;
    endcase
    alu_zero  = (alu_result == 32'd0);
    alu_equal = (alu_a == alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] f3, input logic f7, input logic imm,
                               input logic [31:0] a, input logic [31:0] b,
                               input alu_control_t ctrl, input logic [31:0] ab,
                               input logic [31:0] res, input logic ovf, input logic z,
                               input logic eq, input logic ill);
    vec_t v;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.a = a; v.b = b; v.ctrl = ctrl;
    v.alu_b = ab; v.result = res; v.ovf = ovf; v.zero = z; v.eq = eq; v.ill = ill;
    return v;
  endfunction

  // Reference: RV32I semantics computed directly from the request fields
  function automatic vec_t ref_model(input logic [2:0] f3, input logic f7, input logic imm,
                                     input logic [31:0] a, input logic [31:0] b);
    vec_t   v;
    longint sa, sb, s, maxv, minv;
    int     sh;
    logic [31:0] fill;
    maxv = 64'sh7FFFFFFF;
    minv = -maxv - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.a = a; v.b = b; v.ctrl = ALU_ADD;
    v.ill    = f7 && (f3 != 3'd0) && (f3 != 3'd5);
    v.alu_b  = (!v.ill && (f3 == 3'd1 || f3 == 3'd5)) ? {27'b0, b[4:0]} : b;
    v.result = '0;
    v.ovf    = 1'b0;
    if (!v.ill) begin
      case (f3)
        3'd0: begin
          s = (f7 && !imm) ? sa - sb : sa + sb;
          v.result = s[31:0];
          v.ovf = (s > maxv) || (s < minv);
        end
        3'd1: v.result = a << sh;
        3'd2: v.result = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: v.result = (a < b) ? 32'd1 : 32'd0;
        3'd4: v.result = a ^ b;
        3'd5: begin
          fill = (f7 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
          v.result = (a >> sh) | fill;
        end
        3'd6: v.result = a | b;
        default: v.result = a & b;
      endcase
    end
    v.zero = !v.ill && (v.result == 32'd0);
    v.eq   = !v.ill && (a == v.alu_b);
    return v;
  endfunction

  task automatic chk_stats();
    int exp_ops, exp_ovf;
`ifdef ALU_DRIVER_STATS_EN
    exp_ops = hs_ops;
    exp_ovf = hs_ovf;
`else
    exp_ops = 0;
    exp_ovf = 0;
`endif
    chk("stat_ops", stat_ops, 32'(exp_ops));
    chk("stat_ovf", stat_ovf, 32'(exp_ovf));
  endtask

  // One complete transaction; entered and left at posedge+1 in S_IDLE
  task automatic do_op(input vec_t v, input int hold, input bit chk_ctrl, input bit pulse);
    chk("req_ready_idle", req_ready, 1);
    req_funct3 = v.f3; req_funct7_5 = v.f7; req_is_imm = v.imm;
    req_a = v.a; req_b = v.b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsp_valid_exec", rsp_valid, 0);
    chk("req_ready_exec", req_ready, 0);
    chk("alu_a", alu_a, v.a);
    chk("alu_b", alu_b, v.alu_b);
    if (chk_ctrl) chk("alu_control", alu_control, v.ctrl);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, v.result);
    chk("rsp_overflow", rsp_overflow, v.ovf);
    chk("rsp_zero", rsp_zero, v.zero);
    chk("rsp_equal", rsp_equal, v.eq);
    chk("rsp_illegal", rsp_illegal, v.ill);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        req_valid = 1'b1;
        req_a = ~v.a;
      end
      chk("req_ready_stall", req_ready, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rsp_valid_stall", rsp_valid, 1);
      chk("rsp_result_stall", rsp_result, v.result);
      chk("rsp_illegal_stall", rsp_illegal, v.ill);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    hs_ops++;
    if (v.ovf) hs_ovf++;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("req_ready_done", req_ready, 1);
    chk("alu_a_held", alu_a, v.a);
    chk_stats();
  endtask

  initial begin
    vec_t v;
    logic [2:0]  f3;
    logic        f7, imm;
    logic [31:0] a, b;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_funct3 = '0; req_funct7_5 = 1'b0; req_is_imm = 1'b0; req_a = '0; req_b = '0;

    //             f3    f7    imm   a             b             ctrl      alu_b         result        ovf   z     eq    ill
    vecs.push_back(mkv(3'd0, 1'b0, 1'b0, 32'd7,        32'd5,        ALU_ADD,  32'd5,        32'd12,       1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd0, 1'b1, 1'b0, 32'h80000000, 32'd1,        ALU_SUB,  32'd1,        32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd5, 1'b1, 1'b1, 32'hF0000000, 32'h404,      ALU_SRA,  32'd4,        32'hFF000000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd6, 1'b1, 1'b0, 32'h1234,     32'h5678,     ALU_ADD,  32'h5678,     32'd0,        1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(3'd0, 1'b1, 1'b1, 32'd10,       32'hFFFFFFF6, ALU_ADD,  32'hFFFFFFF6, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd0, 1'b1, 1'b0, 32'h55,       32'h55,       ALU_SUB,  32'h55,       32'd0,        1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkv(3'd1, 1'b0, 1'b0, 32'd1,        32'd31,       ALU_SLL,  32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd1, 1'b0, 1'b1, 32'd3,        32'h23,       ALU_SLL,  32'd3,        32'h18,       1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkv(3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        ALU_SLT,  32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        ALU_SLTU, 32'd1,        32'd0,        1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd4, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, ALU_XOR,  32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd5, 1'b0, 1'b0, 32'hF0000000, 32'd4,        ALU_SRL,  32'd4,        32'h0F000000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd6, 1'b0, 1'b0, 32'h0F,       32'hF0,       ALU_OR,   32'hF0,       32'hFF,       1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd7, 1'b0, 1'b0, 32'hFF,       32'h0F,       ALU_AND,  32'h0F,       32'h0F,       1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd1,        ALU_ADD,  32'd1,        32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(3'd1, 1'b1, 1'b1, 32'd5,        32'h401,      ALU_ADD,  32'h401,      32'd0,        1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(3'd5, 1'b0, 1'b0, 32'd4,        32'd4,        ALU_SRL,  32'd4,        32'd0,        1'b0, 1'b1, 1'b1, 1'b0));

    // Reset values
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_illegal", rsp_illegal, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_control", alu_control, ALU_ADD);
    chk_stats();
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, with varying response hold-off
    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], i % 3, 1'b1, 1'b0);

    // Backpressure for 5 cycles with a request pulse that must be ignored
    do_op(vecs[0], 5, 1'b1, 1'b1);
    chk("no_second_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    chk("no_second_rsp_2", rsp_valid, 0);
    chk("req_ready_after_pulse", req_ready, 1);

    // Asynchronous reset while executing; response must be dropped
    req_funct3 = 3'd0; req_funct7_5 = 1'b0; req_is_imm = 1'b0;
    req_a = 32'd100; req_b = 32'd23; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_in_exec", req_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_control", alu_control, ALU_ADD);
    chk("arst_rsp_result", rsp_result, 0);
    hs_ops = 0;
    hs_ovf = 0;
    chk_stats();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    chk("post_rst_rsp_valid_2", rsp_valid, 0);
    do_op(vecs[1], 0, 1'b1, 1'b0);

    // Randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      f3  = 3'($urandom_range(0, 7));
      f7  = ($urandom_range(0, 3) == 0);
      imm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 32'h80000000 ^ 32'($urandom_range(0, 3));
        1:       a = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      v = ref_model(f3, f7, imm, a, b);
      do_op(v, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
